// File: rtl/frame_buf_pkg.sv
// Shared definitions for the rotation frame-buffer read/write burst controllers.
package frame_buf_pkg;

  localparam int unsigned IDX_W           = 2;
  localparam int unsigned FRAME_WORDS_DEF = 1000;
  localparam int unsigned SLOT_STRIDE_DEF = 32'h0008_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_start_detect.sv
// Two-flop rising-edge detector on the frame-start level; shared with the read side.
module frame_start_detect (
  input  logic clk,
  input  logic rst,
  input  logic new_frame,
  output logic start_c
);

  logic nf_q;
  logic nf_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      nf_q  <= 1'b0;
      nf_qq <= 1'b0;
    end else begin
      nf_q  <= new_frame;
      nf_qq <= nf_q;
    end
  end

  assign start_c = nf_q & ~nf_qq;

endmodule

// File: rtl/frame_wr_burst_ctrl.sv
// Write-side DDR burst controller: drains the pixel FIFO into the current frame slot
// and reports frame completion / abandonment back to the frame-sign generator.
module frame_wr_burst_ctrl
  import frame_buf_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 25,
  parameter int unsigned        LEN_W       = 10,
  parameter int unsigned        FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned        BURST_LEN   = 128,
  parameter logic [ADDR_W-1:0]  SLOT_STRIDE = ADDR_W'(SLOT_STRIDE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_frame,
  input  logic [IDX_W-1:0]  new_write_index,
  input  logic [LEN_W-1:0]  fifo_rd_count,
  output logic              wr_burst_req,
  output logic [ADDR_W-1:0] wr_burst_addr,
  output logic [LEN_W-1:0]  wr_burst_len,
  input  logic              wr_burst_finish,
  output logic              frame_finish,
  output logic              frame_drop,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic              pending_q, pending_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              finish_q, finish_d;
  logic              drop_q, drop_d;
  logic              busy_q, busy_d;

  logic              start_c;
  logic              restart_c;
  logic [ADDR_W-1:0] new_base_c;
  logic [ADDR_W-1:0] remain_c;
  logic [LEN_W-1:0]  len_c;
  logic [ADDR_W-1:0] sum_c;

  frame_start_detect u_start_detect (
    .clk       (clk),
    .rst       (rst),
    .new_frame (new_frame),
    .start_c   (start_c)
  );

  // A start deferred from BURST behaves like a fresh start once the burst is over.
  assign restart_c  = start_c | pending_q;
  assign new_base_c = ADDR_W'(ADDR_W'(new_write_index) * SLOT_STRIDE);
  assign remain_c   = ADDR_W'(FRAME_WORDS) - word_cnt_q;
  assign len_c      = (remain_c > ADDR_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remain_c);
  assign sum_c      = word_cnt_q + ADDR_W'(len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      word_cnt_q <= '0;
      pending_q  <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      finish_q   <= 1'b0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_cnt_q <= word_cnt_d;
      pending_q  <= pending_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      finish_q   <= finish_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_cnt_d = word_cnt_q;
    pending_d  = pending_q;
    req_d      = req_q;
    addr_d     = addr_q;
    len_d      = len_q;
    finish_d   = 1'b0;
    drop_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (restart_c) begin
          base_d     = new_base_c;
          word_cnt_d = '0;
          pending_d  = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (restart_c) begin
          base_d     = new_base_c;
          word_cnt_d = '0;
          pending_d  = 1'b0;
          drop_d     = (word_cnt_q != '0);
        end else if (fifo_rd_count >= len_c) begin
          addr_d  = base_q + word_cnt_q;
          len_d   = len_c;
          req_d   = 1'b1;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (start_c) pending_d = 1'b1;
        if (wr_burst_finish) begin
          req_d      = 1'b0;
          word_cnt_d = sum_c;
          if (sum_c == ADDR_W'(FRAME_WORDS)) begin
            finish_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        // A start queued behind the final burst begins the next frame cleanly.
        if (restart_c) begin
          base_d     = new_base_c;
          word_cnt_d = '0;
          pending_d  = 1'b0;
          state_d    = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign wr_burst_req  = req_q;
  assign wr_burst_addr = addr_q;
  assign wr_burst_len  = len_q;
  assign frame_finish  = finish_q;
  assign frame_drop    = drop_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_frame_wr_burst_ctrl.sv
// Directed bench for frame_wr_burst_ctrl: burst table for a full frame plus hand-built corner sequences.
module tb_frame_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_frame;
  logic [1:0]  new_write_index;
  logic [9:0]  fifo_rd_count;
  logic        wr_burst_req;
  logic [24:0] wr_burst_addr;
  logic [9:0]  wr_burst_len;
  logic        wr_burst_finish;
  logic        frame_finish;
  logic        frame_drop;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;
  int ff_cnt   = 0;

  typedef struct {
    logic [24:0] addr;
    logic [9:0]  len;
    bit          nf_during;
    bit          last;
  } burst_vec_t;

  burst_vec_t vecs [8];

  frame_wr_burst_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .new_frame       (new_frame),
    .new_write_index (new_write_index),
    .fifo_rd_count   (fifo_rd_count),
    .wr_burst_req    (wr_burst_req),
    .wr_burst_addr   (wr_burst_addr),
    .wr_burst_len    (wr_burst_len),
    .wr_burst_finish (wr_burst_finish),
    .frame_finish    (frame_finish),
    .frame_drop      (frame_drop),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_drop)   drop_cnt++;
    if (frame_finish) ff_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!wr_burst_req && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(wr_burst_req), 32'd1);
  endtask

  task automatic finish_burst(input string name);
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
    check(name, 32'(wr_burst_req), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},  32'(wr_burst_req),  32'd0);
    check({tag, "_addr"}, 32'(wr_burst_addr), 32'd0);
    check({tag, "_len"},  32'(wr_burst_len),  32'd0);
    check({tag, "_ff"},   32'(frame_finish),  32'd0);
    check({tag, "_drop"}, 32'(frame_drop),    32'd0);
    check({tag, "_busy"}, 32'(busy),          32'd0);
  endtask

  initial begin
    vecs[0] = '{25'h0080000, 10'd128, 1'b0, 1'b0};
    vecs[1] = '{25'h0080080, 10'd128, 1'b0, 1'b0};
    vecs[2] = '{25'h0080100, 10'd128, 1'b0, 1'b0};
    vecs[3] = '{25'h0080180, 10'd128, 1'b0, 1'b0};
    vecs[4] = '{25'h0080200, 10'd128, 1'b0, 1'b0};
    vecs[5] = '{25'h0080280, 10'd128, 1'b0, 1'b0};
    vecs[6] = '{25'h0080300, 10'd128, 1'b0, 1'b0};
    vecs[7] = '{25'h0080380, 10'd104, 1'b1, 1'b1};

    rst = 1'b1; new_frame = 1'b0; new_write_index = 2'd0;
    fifo_rd_count = 10'd0; wr_burst_finish = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Full frame into slot 1; a new frame (slot 2) arrives during the final burst.
    fifo_rd_count = 10'd200;
    new_frame = 1'b1; new_write_index = 2'd1;
    tick(); tick(); tick();
    new_frame = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_req($sformatf("b%0d_req", i));
      check($sformatf("b%0d_addr", i), 32'(wr_burst_addr), 32'(vecs[i].addr));
      check($sformatf("b%0d_len", i),  32'(wr_burst_len),  32'(vecs[i].len));
      if (vecs[i].nf_during) begin
        new_frame = 1'b1; new_write_index = 2'd2;
      end
      for (int k = 0; k < 4; k++) tick();
      new_frame = 1'b0;
      check($sformatf("b%0d_hold_req", i),  32'(wr_burst_req),  32'd1);
      check($sformatf("b%0d_hold_addr", i), 32'(wr_burst_addr), 32'(vecs[i].addr));
      check($sformatf("b%0d_busy", i),      32'(busy),          32'd1);
      finish_burst($sformatf("b%0d_req_drop", i));
      check($sformatf("b%0d_ff", i), 32'(frame_finish), 32'(vecs[i].last));
    end

    // Pending start from the final burst: slot 2 follows with FIFO starved at 100.
    fifo_rd_count = 10'd100;
    tick();
    check("ff_one_cycle", 32'(frame_finish), 32'd0);
    check("busy_after_done", 32'(busy), 32'd1);
    for (int k = 0; k < 5; k++) tick();
    check("req_low_fifo100", 32'(wr_burst_req), 32'd0);
    fifo_rd_count = 10'd128;
    tick();
    check("req_next_cycle", 32'(wr_burst_req), 32'd1);
    check("slot2_addr", 32'(wr_burst_addr), 32'h0010_0000);
    check("slot2_len",  32'(wr_burst_len),  32'd128);
    check("no_drop_pending", 32'(drop_cnt), 32'd0);
    finish_burst("slot2_b0_done");
    wait_req("slot2_b1_req");
    check("slot2_b1_addr", 32'(wr_burst_addr), 32'h0010_0080);
    fifo_rd_count = 10'd0;
    tick();
    finish_burst("slot2_b1_done");

    // Start in WAIT with 256 words written: partial frame dropped, slot 3 from offset 0.
    tick(); tick();
    check("wait_starved", 32'(wr_burst_req), 32'd0);
    new_frame = 1'b1; new_write_index = 2'd3;
    tick();
    check("drop_not_yet", 32'(frame_drop), 32'd0);
    tick();
    check("drop_pulse", 32'(frame_drop), 32'd1);
    tick();
    check("drop_one_cycle", 32'(frame_drop), 32'd0);
    new_frame = 1'b0;
    fifo_rd_count = 10'd200;
    wait_req("slot3_req");
    check("slot3_addr", 32'(wr_burst_addr), 32'h0018_0000);
    check("slot3_len",  32'(wr_burst_len),  32'd128);
    check("drop_total", 32'(drop_cnt), 32'd1);

    // Reset in the middle of a burst.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("midrst");

    // Burst finish while IDLE is ignored.
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
    tick(); tick();
    check("idle_fin_busy", 32'(busy), 32'd0);
    check("idle_fin_req",  32'(wr_burst_req), 32'd0);
    check("ff_total", 32'(ff_cnt), 32'd1);

    // Fresh frame into slot 0 starts at offset 0.
    new_frame = 1'b1; new_write_index = 2'd0;
    tick(); tick(); tick();
    new_frame = 1'b0;
    wait_req("slot0_req");
    check("slot0_addr", 32'(wr_burst_addr), 32'h0000_0000);
    check("slot0_len",  32'(wr_burst_len),  32'd128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
